decoder_3to8_pulse: RTL

Registered 3-to-8 decoder that turns a 3-bit binary code (x = MSB, z = LSB) into a one-hot strobe on d[7:0]. Codes arrive over a valid/ready handshake. Each accepted code drives the matching output line for a programmable number of cycles, followed by a programmable quiet gap. The block is the receive-side counterpart of the 8:3 encoder: it sits downstream of the encoder and regenerates the individual line strobes from the compressed code.

---
 rtl/dec_pkg.sv | 28 ++
 rtl/dec_pulse_timer.sv | 44 ++++
 rtl/decoder_3to8_pulse.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/dec_pkg.sv
// dec_pkg: shared types, widths and helpers for the 3-to-8 pulse decoder.
//   dec_state_e    : IDLE / DRIVE / GAP state encoding
//   CODE_W, OUT_W  : code and strobe widths
//   code_to_onehot : binary code to one-hot strobe
//   even_parity_ok : even-parity check over code bits plus parity bit
package dec_pkg;

  localparam int CODE_W = 3;
  localparam int OUT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } dec_state_e;

  function automatic logic [OUT_W-1:0] code_to_onehot(input logic [CODE_W-1:0] code);
    logic [OUT_W-1:0] one;
    one = {{(OUT_W-1){1'b0}}, 1'b1};
    return one << code;
  endfunction

  // True when the XOR over all bits is zero, i.e. the word has even parity.
  function automatic logic even_parity_ok(input logic [CODE_W:0] bits);
    return ~(^bits);
  endfunction

endpackage

// File: rtl/dec_pulse_timer.sv
// dec_pulse_timer: loadable down-counter shared by the DRIVE and GAP phases.
//   clk, rst     : clock, asynchronous active-high reset (count -> 0)
//   load_i       : load load_val_i this edge (wins over dec_i)
//   load_val_i   : value to load
//   dec_i        : decrement this edge; holds at zero instead of wrapping
//   zero_o       : count is zero
module dec_pulse_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load has priority, decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != {W{1'b0}})) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/decoder_3to8_pulse.sv
// decoder_3to8_pulse: registered 3-to-8 decoder with a timed strobe.
// An accepted code {x,y,z} lights d[code] for PULSE_LEN cycles, then d stays
// low for GAP_LEN cycles before the next code can be accepted.
//   clk, rst       : clock, asynchronous active-high reset
//   en             : gates acceptance only
//   in_valid/ready : code handshake; in_ready = IDLE && en (combinational)
//   x, y, z        : code bits (x = MSB)
//   d              : registered one-hot strobe
//   busy, done     : registered phase flags (done marks the last d-high cycle)
//   dec_count      : registered count of accepted codes, wraps at 256
// Optional macro DEC_PARITY_EN adds input p (even parity over {x,y,z,p}) and
// output err; a code with bad parity is consumed but not decoded.
module decoder_3to8_pulse
  import dec_pkg::*;
#(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             x,
  input  logic             y,
  input  logic             z,
`ifdef DEC_PARITY_EN
  input  logic             p,
  output logic             err,
`endif
  output logic [OUT_W-1:0] d,
  output logic             busy,
  output logic             done,
  output logic [7:0]       dec_count
);

  localparam int MAX_LEN   = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int TW        = $clog2(MAX_LEN + 1);
  // GAP_LEN == 0 never loads the gap value; clamp so no negative is formed.
  localparam int GAP_LOAD  = (GAP_LEN > 0) ? GAP_LEN - 1 : 0;
  localparam logic [TW-1:0] PULSE_LOAD_V = TW'(PULSE_LEN - 1);
  localparam logic [TW-1:0] GAP_LOAD_V   = TW'(GAP_LOAD);

  dec_state_e        state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [OUT_W-1:0]  d_q;
  logic              busy_q;
  logic              done_q;
  logic [7:0]        dec_count_q;
  logic              err_q;

  logic              accept;
  logic              code_ok;
  logic              tmr_load;
  logic [TW-1:0]     tmr_val;
  logic              tmr_dec;
  logic              tmr_zero;

  assign in_ready = (state_q == IDLE) && en;
  assign accept   = in_valid && in_ready;

`ifdef DEC_PARITY_EN
  assign code_ok = even_parity_ok({x, y, z, p});
  assign err     = err_q;
`else
  assign code_ok = 1'b1;
`endif

  dec_pulse_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  // Next-state, code latch and timer control.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    tmr_load = 1'b0;
    tmr_val  = {TW{1'b0}};
    tmr_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && code_ok) begin
          code_d   = {x, y, z};
          tmr_load = 1'b1;
          tmr_val  = PULSE_LOAD_V;
          state_d  = DRIVE;
        end else begin
          state_d  = IDLE;
        end
      end
      DRIVE: begin
        if (tmr_zero) begin
          if (GAP_LEN > 0) begin
            tmr_load = 1'b1;
            tmr_val  = GAP_LOAD_V;
            state_d  = GAP;
          end else begin
            state_d  = IDLE;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      GAP: begin
        if (tmr_zero) begin
          state_d = IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= {CODE_W{1'b0}};
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

  // Registered outputs, each one cycle behind the state that produces it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q         <= {OUT_W{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dec_count_q <= 8'd0;
      err_q       <= 1'b0;
    end else begin
      d_q    <= (state_q == DRIVE) ? code_to_onehot(code_q) : {OUT_W{1'b0}};
      busy_q <= (state_q != IDLE);
      done_q <= (state_q == DRIVE) && tmr_zero;
      if (accept && code_ok) begin
        dec_count_q <= dec_count_q + 8'd1;
      end else begin
        dec_count_q <= dec_count_q;
      end
      err_q  <= accept && !code_ok;
    end
  end

  assign d         = d_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dec_count = dec_count_q;

`ifndef DEC_PARITY_EN
  // err_q only drives a port when parity checking is built in.
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule
